binary_down_counter: RTL and testbench
======================================

// Module: binary_down_counter
//
// PURPOSE
//   Free-running binary down counter: decrements by one every clock and wraps
//   from zero to all-ones. Serves as a general-purpose count-down timebase for
//   sequencing, dividers and demo logic.
//   Single clock domain. Synchronous, active-high reset reloads the start value.
//   A terminal-count flag marks the zero state for downstream cascading.
//
// PARAMETERS
//   WIDTH        4              counter width in bits (>= 1)
//   RESET_VALUE  {WIDTH{1'b1}}  value loaded on reset and at configuration (15 for WIDTH=4)
//
// PORTS
//   clk   in   1      clock; all state changes on rising edge only
//   rst   in   1      reset, synchronous, active-high
//   q     out  WIDTH  current count (registered)
//   tc    out  1      terminal count; high while q == 0 (combinational decode of q)
//
// BEHAVIOUR
//   - Reset: synchronous and active-high. At a rising clk edge with rst=1:
//     q <= RESET_VALUE. The rst input has no effect between edges.
//   - Reset dominates: while rst stays high, q holds RESET_VALUE on every edge.
//   - Count: at a rising clk edge with rst=0: q <= q - 1 (mod 2^WIDTH).
//   - Wrap-around: q == 0 -> next q == {WIDTH{1'b1}}. No stall, no saturation.
//   - Latency: q changes one clk edge after the controlling rst level is sampled.
//     The first decrement occurs at the first edge where rst=0 is sampled.
//   - Reset mid-count: any q value is replaced by RESET_VALUE at the next edge
//     with rst=1. Counting resumes from RESET_VALUE at the first edge after rst
//     falls, giving RESET_VALUE-1.
//   - Power-up: the q register carries initial value RESET_VALUE in both
//     simulation and FPGA configuration. Without any reset, the first edge
//     therefore gives RESET_VALUE-1. q is never X.
//   - tc: tc = (q == 0). Derived from the register, so it is glitch-free
//     relative to q. tc is high for exactly one cycle per 2^WIDTH-cycle period
//     when free-running.
//   - Reset output values: q = RESET_VALUE; tc = (RESET_VALUE == 0).
//   - Arithmetic: unsigned, WIDTH bits. The borrow out of bit WIDTH-1 is
//     discarded.
//   - No enable or load inputs. The counter is strictly free-running outside
//     reset.
//
// TESTING
//   1. Power-up, rst=0, 10 ns clk:
//      -> q = 15,14,13,...,1,0,15 on successive edges; never X.
//   2. Wrap: run 17 edges from 15
//      -> q goes 0 -> 15 with no extra cycle; tc=1 only while q=0.
//   3. Hold rst=1 for 30 edges
//      -> q = 15 on every edge; tc=0.
//      Release rst -> next edge q = 14.
//   4. Mid-count reset: assert rst for one edge when q=6
//      -> next q = 15, then 14, 13, ...
//   5. Reset pulse between edges (rst high and low with no rising clk edge)
//      -> q unaffected; counting continues.
//   6. Parameter sweep: WIDTH=1 gives q toggling 1,0,1,...;
//      WIDTH=8 with RESET_VALUE=8'h05 gives 5,4,3,2,1,0,255,254.

Source files
------------

// File: rtl/binary_down_counter.sv
// Free-running WIDTH-bit binary down counter with terminal-count decode.
// Wraps from zero to all-ones; synchronous reset reloads RESET_VALUE.
module binary_down_counter #(
    parameter int               WIDTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] q,
    output logic             tc
);

    // Initialiser gives the configured power-up value, so q is never X.
    logic [WIDTH-1:0] q_reg = RESET_VALUE;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] borrow;

    // Ripple-borrow decrement: bit flips while every lower bit is zero.
    assign borrow[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign q_next[gi] = q_reg[gi] ^ borrow[gi];
            if (gi < WIDTH - 1) begin : g_borrow
                assign borrow[gi+1] = borrow[gi] & ~q_reg[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg <= RESET_VALUE;
        end else begin
            q_reg <= q_next;
        end
    end

    assign q  = q_reg;
    assign tc = (q_reg == '0);

endmodule

// File: tb/tb_binary_down_counter.sv
// Self-checking bench: three counter configurations checked every cycle
// against a modular-arithmetic model, plus directed literal checks.
module tb_binary_down_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] q4;
    logic       tc4;
    logic [0:0] q1;
    logic       tc1;
    logic [7:0] q8;
    logic       tc8;

    int asserts  = 0;
    int failures = 0;

    // Model state: counts modulo 2^WIDTH, starting at each power-up value.
    int m4 = 15;
    int m1 = 1;
    int m8 = 5;

    always #5 clk = ~clk;

    binary_down_counter #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .q(q4), .tc(tc4)
    );
    binary_down_counter #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .q(q1), .tc(tc1)
    );
    binary_down_counter #(.WIDTH(8), .RESET_VALUE(8'h05)) dut8 (
        .clk(clk), .rst(rst), .q(q8), .tc(tc8)
    );

    task automatic check(input string name, input int act, input int exp);
        asserts++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        m4 <= rst ? 15 : (m4 + 15) % 16;
        m1 <= rst ? 1  : (m1 + 1) % 2;
        m8 <= rst ? 5  : (m8 + 255) % 256;
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("model_q4", int'(q4), m4);
        check("model_tc4", int'(tc4), int'(m4 == 0));
        check("model_q1", int'(q1), m1);
        check("model_tc1", int'(tc1), int'(m1 == 0));
        check("model_q8", int'(q8), m8);
        check("model_tc8", int'(tc8), int'(m8 == 0));
    end

    initial begin
        int prev;
        bit found;

        #1;
        check("pu_q4", int'(q4), 15);
        check("pu_q1", int'(q1), 1);
        check("pu_q8", int'(q8), 5);
        check("pu_tc4", int'(tc4), 0);

        // Power-up run through one full wrap, no reset at all.
        for (int i = 1; i <= 17; i++) begin
            @(negedge clk);
            #1;
            check("run_q4", int'(q4), (15 - i + 32) % 16);
            check("run_tc4", int'(tc4), int'(((15 - i + 32) % 16) == 0));
            check("run_q1", int'(q1), (1 + i) % 2);
            check("run_q8", int'(q8), (5 - i + 256) % 256);
        end
        $display("phase power-up/wrap done at %0t, q4=%0d q8=%0d", $time, q4, q8);

        // Reset held for 30 edges.
        rst = 1'b1;
        repeat (30) begin
            @(negedge clk);
            #1;
            check("hold_q4", int'(q4), 15);
            check("hold_tc4", int'(tc4), 0);
            check("hold_q8", int'(q8), 5);
        end
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("release_q4", int'(q4), 14);
        check("release_q8", int'(q8), 4);
        $display("phase reset-hold done at %0t, q4=%0d", $time, q4);

        // Mid-count reset when q4 reaches 6.
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            #1;
            if (q4 == 4'd6) found = 1'b1;
        end
        asserts++;
        if (!found) begin
            failures++;
            $display("FAIL midreset_wait: q4=%0d never reached 6", q4);
        end
        rst = 1'b1;
        @(negedge clk);
        #1;
        rst = 1'b0;
        check("midreset_q4", int'(q4), 15);
        @(negedge clk);
        #1;
        check("midreset_next_q4", int'(q4), 14);
        @(negedge clk);
        #1;
        check("midreset_next2_q4", int'(q4), 13);
        $display("phase mid-count reset done at %0t, q4=%0d", $time, q4);

        // Reset glitch between edges must be ignored.
        prev = int'(q4);
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        @(negedge clk);
        #1;
        check("glitch_q4", int'(q4), (prev + 15) % 16);
        $display("phase reset glitch done at %0t, q4=%0d", $time, q4);

        // Randomised reset activity; model compare runs every cycle.
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            #1;
            rst = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 15) == 0) begin
                #2 rst = ~rst;
            end
        end
        rst = 1'b0;
        @(negedge clk);
        $display("phase random done at %0t", $time);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
